alu_seq: RTL and testbench

- Parametrised, handshaked, sequential successor to the team's combinational 16-bit ALU for the CR16-style datapath.
- Adds a persistent processor-status flag register, and a carry-in add (ADDC) that consumes the stored carry.
- Adds an iterative one-bit-per-cycle shifter with variable latency.
- Sits between the register-file read stage and writeback; one operation in flight at a time.

---
 rtl/alu_seq.sv | 247 ++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU for the CR16-style datapath.
// Accepts one operation at a time. Most operations complete one cycle after
// the accept edge. LSH and ARSH run on an iterative one-bit-per-cycle shifter,
// so their latency depends on the shift amount. A persistent status register
// holds Z/C/F/N/L, and ADDC consumes the stored carry.
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    request handshake (opcode, a, b captured on accept)
//   out_valid/out_ready  result handshake (result, flags, err held until taken)
//   flags                [4]=Z [3]=C [2]=F [1]=N [0]=L
//   err                  illegal opcode, meaningful while out_valid=1
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags,
    output logic             err
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_ADDU = 5'b00001;
    localparam logic [4:0] OP_ADDC = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_CMP  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_XOR  = 5'b00111;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_LSH  = 5'b01001;
    localparam logic [4:0] OP_ARSH = 5'b01010;
    localparam logic [4:0] OP_MOV  = 5'b01011;
    localparam logic [4:0] OP_NOP  = 5'b01100;

    localparam logic [SW-1:0] WIDTH_CNT = SW'(WIDTH);
    localparam logic [SW-1:0] ONE_CNT   = SW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] work_r;
    logic [SW-1:0]    cnt_r;
    logic             shl_r;
    logic             arith_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic [4:0]       flags_r;
    logic             err_r;

    logic             cin_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [SW-1:0]    amt_s;
    logic [SW-1:0]    mag_s;
    logic [SW-1:0]    shift_cnt_s;
    logic             shl_s;
    logic             arith_s;
    logic             is_shift_s;
    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] nxt_result_s;
    logic [4:0]       nxt_flags_s;
    logic             nxt_err_s;

    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    // Adder/subtractor shared by the arithmetic opcodes; diff_s[WIDTH] is the borrow.
    always_comb begin
        cin_s  = (opcode == OP_ADDC) ? flags_r[3] : 1'b0;
        sum_s  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_s};
        diff_s = {1'b0, a} - {1'b0, b};
    end

    // Decode shift direction and iteration count; LSH amounts are signed, ARSH unsigned.
    always_comb begin
        amt_s   = b[SW-1:0];
        shl_s   = 1'b0;
        arith_s = 1'b0;
        mag_s   = amt_s;
        if (opcode == OP_LSH) begin
            if (amt_s[SW-1]) begin
                mag_s = -amt_s;
                shl_s = 1'b0;
            end else begin
                mag_s = amt_s;
                shl_s = 1'b1;
            end
        end else if (opcode == OP_ARSH) begin
            arith_s = 1'b1;
        end else begin
            arith_s = 1'b0;
        end
        // Saturating at WIDTH steps already gives the all-zero / all-sign result.
        shift_cnt_s = (mag_s > WIDTH_CNT) ? WIDTH_CNT : mag_s;
        is_shift_s  = (opcode == OP_LSH) || (opcode == OP_ARSH);
    end

    // One bit of shifting per cycle on the working register.
    always_comb begin
        if (shl_r) begin
            step_s = {work_r[WIDTH-2:0], 1'b0};
        end else if (arith_r) begin
            step_s = {work_r[WIDTH-1], work_r[WIDTH-1:1]};
        end else begin
            step_s = {1'b0, work_r[WIDTH-1:1]};
        end
    end

    // Single-cycle result and flag update for everything except a real shift.
    always_comb begin
        nxt_result_s = {WIDTH{1'b0}};
        nxt_flags_s  = flags_r;
        nxt_err_s    = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDU, OP_ADDC: begin
                nxt_result_s   = sum_s[WIDTH-1:0];
                nxt_flags_s[4] = is_zero(sum_s[WIDTH-1:0]);
                nxt_flags_s[3] = sum_s[WIDTH];
                nxt_flags_s[2] = (opcode != OP_ADDU) && (a[WIDTH-1] == b[WIDTH-1]) &&
                                 (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                nxt_result_s   = diff_s[WIDTH-1:0];
                nxt_flags_s[4] = is_zero(diff_s[WIDTH-1:0]);
                nxt_flags_s[3] = diff_s[WIDTH];
                nxt_flags_s[2] = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_CMP: begin
                nxt_flags_s[4] = (a == b);
                nxt_flags_s[1] = ($signed(a) < $signed(b));
                nxt_flags_s[0] = diff_s[WIDTH];
            end
            OP_AND: begin
                nxt_result_s   = a & b;
                nxt_flags_s[4] = is_zero(a & b);
            end
            OP_OR: begin
                nxt_result_s   = a | b;
                nxt_flags_s[4] = is_zero(a | b);
            end
            OP_XOR: begin
                nxt_result_s   = a ^ b;
                nxt_flags_s[4] = is_zero(a ^ b);
            end
            OP_NOT: begin
                nxt_result_s   = ~a;
                nxt_flags_s[4] = is_zero(~a);
            end
            OP_LSH, OP_ARSH: begin
                // Only reached with a zero amount; nonzero amounts go through SHIFT.
                nxt_result_s   = a;
                nxt_flags_s[4] = is_zero(a);
            end
            OP_MOV: begin
                nxt_result_s = b;
            end
            OP_NOP: begin
                nxt_result_s = {WIDTH{1'b0}};
            end
            default: begin
                nxt_err_s = 1'b1;
            end
        endcase
    end

    // Control FSM with registered handshake, result, flag and error outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            work_r      <= {WIDTH{1'b0}};
            cnt_r       <= {SW{1'b0}};
            shl_r       <= 1'b0;
            arith_r     <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            flags_r     <= 5'b00000;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready_r <= 1'b0;
                        if (is_shift_s && (shift_cnt_s != {SW{1'b0}})) begin
                            state_r <= ST_SHIFT;
                            work_r  <= a;
                            cnt_r   <= shift_cnt_s;
                            shl_r   <= shl_s;
                            arith_r <= arith_s;
                        end else begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                            result_r    <= nxt_result_s;
                            flags_r     <= nxt_flags_s;
                            err_r       <= nxt_err_s;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_r <= step_s;
                    cnt_r  <= cnt_r - ONE_CNT;
                    if (cnt_r == ONE_CNT) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= step_s;
                        flags_r     <= {is_zero(step_s), flags_r[3:0]};
                        err_r       <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign flags     = flags_r;
    assign err       = err_r;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=16). Directed operations
// followed by random ones, each compared against an arithmetic reference model
// that also tracks the persistent status flags.
module tb_alu_seq;

    localparam int W  = 16;
    localparam int SW = $clog2(W) + 1;

    localparam logic [4:0] ADD  = 5'd0;
    localparam logic [4:0] ADDU = 5'd1;
    localparam logic [4:0] ADDC = 5'd2;
    localparam logic [4:0] SUB  = 5'd3;
    localparam logic [4:0] CMP  = 5'd4;
    localparam logic [4:0] ANDO = 5'd5;
    localparam logic [4:0] ORO  = 5'd6;
    localparam logic [4:0] XORO = 5'd7;
    localparam logic [4:0] NOTO = 5'd8;
    localparam logic [4:0] LSH  = 5'd9;
    localparam logic [4:0] ARSH = 5'd10;
    localparam logic [4:0] MOV  = 5'd11;
    localparam logic [4:0] NOP  = 5'd12;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [4:0]   flags;
    logic         err;

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [4:0]   flags_m  = 5'b00000;
    logic [W-1:0] last_res;
    logic [4:0]   last_flags;
    int           last_lat;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic void model(input logic [4:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic [4:0] fin, output logic [W-1:0] r,
                                  output logic [4:0] f, output logic e, output int lat);
        longint full, half, ua, ub, sa, sb, s, ss, amt, mag;
        full = longint'(1) << W;
        half = full / 2;
        ua   = longint'(av);
        ub   = longint'(bv);
        sa   = (ua >= half) ? ua - full : ua;
        sb   = (ub >= half) ? ub - full : ub;
        f    = fin;
        e    = 1'b0;
        lat  = 1;
        r    = '0;
        case (op)
            ADD, ADDU, ADDC: begin
                s    = ua + ub + ((op == ADDC) ? longint'(fin[3]) : 0);
                ss   = sa + sb + ((op == ADDC) ? longint'(fin[3]) : 0);
                r    = W'(s);
                f[4] = (r == '0);
                f[3] = (s >= full);
                f[2] = (op != ADDU) && (ss >= half || ss < -half);
            end
            SUB: begin
                s    = ua - ub;
                ss   = sa - sb;
                r    = W'(s < 0 ? s + full : s);
                f[4] = (r == '0);
                f[3] = (ua < ub);
                f[2] = (ss >= half || ss < -half);
            end
            CMP: begin
                f[4] = (ua == ub);
                f[1] = (sa < sb);
                f[0] = (ua < ub);
            end
            ANDO: begin r = av & bv; f[4] = (r == '0); end
            ORO:  begin r = av | bv; f[4] = (r == '0); end
            XORO: begin r = av ^ bv; f[4] = (r == '0); end
            NOTO: begin r = ~av;     f[4] = (r == '0); end
            LSH: begin
                amt = longint'(bv[SW-1:0]);
                if (amt >= (longint'(1) << (SW - 1))) amt = amt - (longint'(1) << SW);
                mag = (amt < 0) ? -amt : amt;
                lat = 1 + int'((mag > W) ? W : mag);
                if (mag >= W) r = '0;
                else if (amt >= 0) r = W'(ua << amt);
                else r = W'(ua >> mag);
                f[4] = (r == '0);
            end
            ARSH: begin
                amt = longint'(bv[SW-1:0]);
                lat = 1 + int'((amt > W) ? W : amt);
                if (amt >= W) r = av[W-1] ? {W{1'b1}} : {W{1'b0}};
                else r = W'(sa >>> amt);
                f[4] = (r == '0);
            end
            MOV: r = bv;
            NOP: r = '0;
            default: e = 1'b1;
        endcase
    endfunction

    // Issue one operation, check latency/result/flags/err, hold for 'hold' cycles, then take it.
    task automatic run_op(input logic [4:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input int hold);
        logic [W-1:0] er;
        logic [4:0]   ef;
        logic         ee;
        int           el;
        int           lat;
        model(op, av, bv, flags_m, er, ef, ee, el);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        opcode   = op;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
        lat = 1;
        // Junk on the inputs after accept must not disturb the operation.
        in_valid = 1'b1;
        opcode   = 5'($urandom);
        a        = W'($urandom);
        b        = W'($urandom);
        while (out_valid !== 1'b1 && lat < 40) begin
            check("in_ready_busy", in_ready, 0);
            out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        out_ready = 1'b0;
        check("latency", lat, el);
        check("out_valid", out_valid, 1);
        check("result", result, er);
        check("flags", flags, ef);
        check("err", err, ee);
        check("in_ready_done", in_ready, 0);
        last_res   = result;
        last_flags = flags;
        last_lat   = lat;
        flags_m    = ef;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", out_valid, 1);
            check("hold_result", result, er);
            check("hold_flags", flags, ef);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = 5'd0;
        a         = '0;
        b         = '0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        check("rst_err", err, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op(ADD, 16'h7FFF, 16'h0001, 0);
        check("tp_add_res", last_res, 16'h8000);
        check("tp_add_flags", last_flags, 5'b00100);
        check("tp_add_lat", last_lat, 1);
        run_op(ADDU, 16'hFFFF, 16'h0001, 0);
        check("tp_addu_flags", last_flags, 5'b11000);
        run_op(ADDC, 16'h0001, 16'h0001, 1);
        check("tp_addc_res", last_res, 16'h0003);
        check("tp_addc_flags", last_flags, 5'b00000);
        run_op(CMP, 16'hFFFE, 16'h0001, 0);
        check("tp_cmp1_flags", last_flags, 5'b00010);
        run_op(CMP, 16'h1234, 16'h1234, 0);
        check("tp_cmp2_flags", last_flags, 5'b10000);
        run_op(LSH, 16'h0001, 16'h0003, 0);
        check("tp_lsh_res", last_res, 16'h0008);
        check("tp_lsh_lat", last_lat, 4);
        run_op(LSH, 16'h8000, 16'hFFFF, 0);
        check("tp_lshneg_res", last_res, 16'h4000);
        run_op(ARSH, 16'h8000, 16'h0004, 0);
        check("tp_arsh_res", last_res, 16'hF800);
        run_op(LSH, 16'h0001, 16'h0010, 0);
        check("tp_lshbig_res", last_res, 16'h0000);
        check("tp_lshbig_lat", last_lat, 17);
        run_op(XORO, 16'h00FF, 16'h0F0F, 5);
        check("tp_xor_res", last_res, 16'h0FF0);
        run_op(ADDU, 16'hFFFF, 16'h0001, 0);
        run_op(ANDO, 16'h00F0, 16'h0F00, 0);
        check("tp_and_flags", last_flags, 5'b11000);
        run_op(5'b11111, 16'h1234, 16'h5678, 0);
        check("tp_ill_res", last_res, 16'h0000);
        check("tp_ill_flags", last_flags, 5'b11000);
        run_op(ARSH, 16'h8001, 16'h001F, 0);
        run_op(LSH, 16'h1234, 16'h0000, 0);
        run_op(SUB, 16'h8000, 16'h0001, 0);

        for (int i = 0; i < 300; i++) begin
            logic [4:0] op;
            if ($urandom_range(0, 15) == 0) op = 5'($urandom_range(13, 31));
            else op = 5'($urandom_range(0, 12));
            run_op(op, W'($urandom), W'($urandom), int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a long shift.
        run_op(ADDU, 16'hFFFF, 16'h0001, 0);
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = LSH;
        a        = 16'h0001;
        b        = 16'h000F;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("mid_shift_valid", out_valid, 0);
        check("mid_shift_ready", in_ready, 0);
        reset = 1'b1;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_ready", in_ready, 1);
        check("rst_mid_flags", flags, 0);
        check("rst_mid_result", result, 0);
        flags_m = 5'b00000;
        @(negedge clk);
        reset = 1'b0;
        run_op(ADDU, 16'h0003, 16'h0004, 0);
        check("post_rst_res", last_res, 16'h0007);
        run_op(LSH, 16'h0001, 16'h0002, 0);
        check("post_rst_lsh", last_res, 16'h0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
